// File: rtl/counter_scheduler.sv
// Round-robin arbiter that time-shares one up/down counter among NUM_REQ requesters,
// steering it along the shortest modulo-2^CW path to each granted target.
module counter_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CW      = 5,
  parameter int unsigned IDW     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*CW-1:0] tgt,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic                  busy,
  output logic                  cnt_en,
  output logic                  cnt_sel,
  input  logic [CW-1:0]         cnt_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       cur_q, cur_d;
  logic [CW-1:0]        tgt_q, tgt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 done_q, done_d;
  logic [IDW-1:0]       done_id_q, done_id_d;

  logic                 win_vld;
  logic [IDW-1:0]       win_idx;
  logic [IDW-1:0]       cand;
  logic [CW-1:0]        dist_up;
  logic [CW-1:0]        dist_dn;

  // First pending request at or after ptr, wrapping around.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((32'(ptr_q) + k) % NUM_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign dist_up = tgt_q - cnt_out;
  assign dist_dn = cnt_out - tgt_q;

  // Next-state and counter steering; counter controls depend only on state, tgt_q, cnt_out.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    gnt_d     = '0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    cnt_en    = 1'b0;
    cnt_sel   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          cur_d   = win_idx;
          tgt_d   = tgt[32'(win_idx)*CW +: CW];
          gnt_d   = NUM_REQ'(1) << win_idx;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_out == tgt_q) begin
          done_d    = 1'b1;
          done_id_d = cur_q;
          state_d   = DONE;
        end else begin
          cnt_en  = 1'b1;
          cnt_sel = (dist_dn < dist_up);
        end
      end
      DONE: begin
        ptr_d   = IDW'((32'(cur_q) + 32'd1) % NUM_REQ);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cur_q     <= '0;
      tgt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign busy    = (state_q == RUN) || (state_q == DONE);

endmodule

// File: tb/tb_counter_scheduler.sv
// Scoreboard bench for counter_scheduler with a behavioural 5-bit up/down counter attached.
module tb_counter_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CW      = 5;
  localparam int unsigned IDW     = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ*CW-1:0] tgt = '0;
  logic [NUM_REQ-1:0]    gnt;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic                  busy;
  logic                  cnt_en;
  logic                  cnt_sel;
  logic [CW-1:0]         cnt_out;

  logic                  ld = 1'b1;
  logic [CW-1:0]         ld_val = '0;

  typedef struct {
    int id;
    int d;
    int dir;
    int tgt;
  } op_t;

  op_t exp_q[$];
  op_t cur_op;
  bit  active = 1'b0;
  int  cyc, en_n, sel_bad;
  int  errors = 0;
  int  checks = 0;

  counter_scheduler #(.NUM_REQ(NUM_REQ), .CW(CW), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req(req), .tgt(tgt), .gnt(gnt), .done(done),
    .done_id(done_id), .busy(busy), .cnt_en(cnt_en), .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  // Counter datapath model, with a preload hook for setting up start positions.
  always @(posedge clk) begin
    if (ld) cnt_out <= ld_val;
    else if (cnt_en) cnt_out <= cnt_sel ? cnt_out - 5'd1 : cnt_out + 5'd1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input int d, input int dir, input int t);
    op_t o;
    o.id = id; o.d = d; o.dir = dir; o.tgt = t;
    exp_q.push_back(o);
  endtask

  // Monitor: pops an expected operation at each grant, checks it at the done pulse.
  always @(negedge clk) begin
    if (reset) begin
      active = 1'b0;
    end else if (gnt != '0) begin
      chk("gnt_onehot", int'($onehot(gnt)), 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_gnt", int'(gnt), 0);
      end else begin
        cur_op = exp_q.pop_front();
        chk("gnt_id", int'(gnt), 1 << cur_op.id);
        active  = 1'b1;
        cyc     = 0;
        en_n    = cnt_en ? 1 : 0;
        sel_bad = (cnt_en && int'(cnt_sel) != cur_op.dir) ? 1 : 0;
      end
    end else if (active) begin
      cyc++;
      if (cnt_en) begin
        en_n++;
        if (int'(cnt_sel) != cur_op.dir) sel_bad++;
      end else if (cnt_sel) begin
        sel_bad++;
      end
      if (done) begin
        chk("done_id", int'(done_id), cur_op.id);
        chk("done_latency", cyc, cur_op.d + 1);
        chk("en_cycles", en_n, cur_op.d);
        chk("cnt_at_done", int'(cnt_out), cur_op.tgt);
        chk("sel_errors", sel_bad, 0);
        active = 1'b0;
      end
    end else if (done) begin
      chk("unexpected_done", int'(done), 0);
    end
  end

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      req = req & ~gnt;
      if (req == '0 && exp_q.size() == 0 && !active && !busy && !done) return;
    end
    chk("drain_timeout", 1, 0);
  endtask

  task automatic load(input logic [CW-1:0] v);
    ld_val = v;
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  initial begin
    // Reset held with all requests up; afterwards requesters 0..3 run in turn.
    req = 4'b1111;
    tgt = {5'd18, 5'd2, 5'd30, 5'd5};
    push(0, 5, 0, 5);
    push(1, 7, 1, 30);
    push(2, 4, 0, 2);
    push(3, 16, 0, 18);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_cnt_en", int'(cnt_en), 0);
      chk("rst_busy", int'(busy), 0);
    end
    chk("rst_done_id", int'(done_id), 0);
    reset = 1'b0;
    ld = 1'b0;
    drain(400);
    chk("cnt_after_seq_a", int'(cnt_out), 18);

    // Zero-distance op on requester 0 moves ptr to 1, then four-way contention.
    load(5'd7);
    push(0, 0, 0, 7);
    tgt[0 +: CW] = 5'd7;
    req = 4'b0001;
    drain(100);
    push(1, 2, 0, 9);
    push(2, 3, 1, 6);
    push(3, 0, 0, 6);
    push(0, 7, 1, 31);
    tgt = {5'd6, 5'd6, 5'd9, 5'd31};
    req = 4'b1111;
    drain(400);

    // Reset three steps into a 10-step op on requester 1.
    load(5'd0);
    push(1, 10, 0, 10);
    tgt[CW +: CW] = 5'd10;
    req = 4'b0010;
    begin : wait_gnt
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (gnt != '0) disable wait_gnt;
      end
      chk("gnt_timeout", 1, 0);
    end
    req = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrun_cnt_en", int'(cnt_en), 0);
    chk("midrun_busy", int'(busy), 0);
    chk("midrun_cnt_out", int'(cnt_out), 3);
    tgt = {5'd0, 5'd4, 5'd0, 5'd1};
    req = 4'b0101;
    push(0, 2, 1, 1);
    push(2, 3, 0, 4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrun_done", int'(done), 0);
      chk("midrun_gnt", int'(gnt), 0);
    end
    reset = 1'b0;
    drain(200);
    chk("final_cnt_out", int'(cnt_out), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
